snake_score_keeper: RTL and testbench

Game-side producer of the 7-bit binary score consumed by the two-digit seven-segment display path. It turns one-bit game events (start, food eaten, death) into a saturating 0–99 score and tracks a session high score. It also derives a speed level from the score and generates the snake's move-tick strobe, whose period shortens as the level rises. It sits between the snake game FSM and the display encoder on the DE2-115.

---
 rtl/snake_score_keeper.sv | 123 ++++++++++++
 tb/tb_snake_score_keeper.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_score_keeper.sv
// Snake game score keeper: saturating 0-99 score, speed level and move-tick strobe.
// Optional session high score / new-record logic is built when SCORE_HISCORE_EN is defined.
module snake_score_keeper #(
    parameter logic [31:0] BASE_TICKS = 32'd5_000_000,
    parameter logic [31:0] STEP_TICKS = 32'd500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       eat,
    input  logic       die,
    output logic [1:0] state,
    output logic [6:0] score,
    output logic [6:0] high_score,
    output logic       new_record,
    output logic [2:0] level,
    output logic       move_tick
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  score_q, score_d;
    logic [31:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;
    logic        eat_q;
    logic        eat_rise;
    logic [6:0]  score_tens;
    logic [31:0] period;

    assign eat_rise   = eat & ~eat_q;
    assign score_tens = score_q / 7'd10;
    assign level      = (score_tens > 7'd7) ? 3'd7 : score_tens[2:0];
    assign period     = BASE_TICKS - (32'(level) * STEP_TICKS);

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        cnt_d   = 32'd0;
        tick_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_PLAY;
                    score_d = 7'd0;
                end
            end
            ST_PLAY: begin
                if (die) begin
                    state_d = ST_OVER;
                end else begin
                    if (eat_rise && (score_q < 7'd99)) begin
                        score_d = score_q + 7'd1;
                    end
                    // >= so a level-up that shrinks the period below the count fires at once
                    if (cnt_q >= period - 32'd1) begin
                        tick_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            score_q <= 7'd0;
            cnt_q   <= 32'd0;
            tick_q  <= 1'b0;
            eat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            eat_q   <= eat;
        end
    end

`ifdef SCORE_HISCORE_EN
    logic [6:0] high_q, high_d;
    logic       rec_q, rec_d;

    always_comb begin
        high_d = high_q;
        rec_d  = rec_q;
        if ((state_q == ST_PLAY) && die && (score_q > high_q)) begin
            high_d = score_q;
            rec_d  = 1'b1;
        end else if ((state_q != ST_PLAY) && start) begin
            rec_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_q <= 7'd0;
            rec_q  <= 1'b0;
        end else begin
            high_q <= high_d;
            rec_q  <= rec_d;
        end
    end

    assign high_score = high_q;
    assign new_record = rec_q;
`else
    assign high_score = 7'd0;
    assign new_record = 1'b0;
`endif

    assign state     = state_q;
    assign score     = score_q;
    assign move_tick = tick_q;

endmodule

// File: tb/tb_snake_score_keeper.sv
// Randomized + directed bench for snake_score_keeper against a game-rule reference model.
module tb_snake_score_keeper;

`ifdef SCORE_HISCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       eat = 1'b0;
    logic       die = 1'b0;
    logic [1:0] state;
    logic [6:0] score;
    logic [6:0] high_score;
    logic       new_record;
    logic [2:0] level;
    logic       move_tick;

    int n_cmp = 0;
    int n_err = 0;
    int n_step = 0;

    // reference model: game phase (0 idle, 1 play, 2 over) and cycles into the current tick period
    int m_state, m_score, m_hs, m_nr, m_eatd, m_ph, m_tick;

    snake_score_keeper #(
        .BASE_TICKS(32'd20),
        .STEP_TICKS(32'd2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .eat(eat), .die(die),
        .state(state), .score(score), .high_score(high_score),
        .new_record(new_record), .level(level), .move_tick(move_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (step %0d)", tag, got, exp, n_step);
        end
    endtask

    function automatic int m_level(input int s);
        return (s / 10 > 7) ? 7 : s / 10;
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_hs = 0; m_nr = 0;
        m_eatd = 0; m_ph = 0; m_tick = 0;
    endtask

    task automatic check_all();
        chk("state", 32'(state), 32'(m_state));
        chk("score", 32'(score), 32'(m_score));
        chk("high_score", 32'(high_score), 32'(m_hs));
        chk("new_record", 32'(new_record), 32'(m_nr));
        chk("level", 32'(level), 32'(m_level(m_score)));
        chk("move_tick", 32'(move_tick), 32'(m_tick));
    endtask

    // one clock: apply inputs, advance the model by the game rules, then compare
    task automatic step(input bit st, input bit e, input bit d);
        int period;
        bit rise;
        start = st; eat = e; die = d;
        @(posedge clk);
        rise = e && (m_eatd == 0);
        period = 20 - m_level(m_score) * 2;
        m_tick = 0;
        if (m_state == 1) begin
            if (d) begin
                m_state = 2;
                if (HS_EN && m_score > m_hs) begin
                    m_hs = m_score;
                    m_nr = 1;
                end
            end else begin
                if (rise) m_score = (m_score + 1 > 99) ? 99 : m_score + 1;
                if (m_ph + 1 >= period) begin
                    m_tick = 1;
                    m_ph = 0;
                end else begin
                    m_ph = m_ph + 1;
                end
            end
        end else if (st) begin
            m_state = 1; m_score = 0; m_nr = 0; m_ph = 0;
        end
        m_eatd = e;
        #1;
        n_step++;
        $display("step %0d st=%0b eat=%0b die=%0b -> state=%0d score=%0d hs=%0d nr=%0b lvl=%0d tick=%0b",
                 n_step, st, e, d, state, score, high_score, new_record, level, move_tick);
        check_all();
    endtask

    task automatic eats(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0);
            step(0, 0, 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_hs", 32'(high_score), 32'd0);
        chk("rst_nr", 32'(new_record), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_tick", 32'(move_tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        hard_reset();

        // start and eat counting, held eat counts once
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
        end
        chk("three_eats", 32'(score), 32'd3);
        for (int i = 0; i < 10; i++) step(0, 1, 0);
        step(0, 0, 0);
        chk("held_eat", 32'(score), 32'd4);
        eats(1);

        // asynchronous reset mid-game with score 5
        chk("pre_reset_score", 32'(score), 32'd5);
        hard_reset();

        // level 0 tick period from PLAY entry
        step(1, 0, 0);
        idle(45);
        // level 3 period
        eats(30);
        chk("score30_level", 32'(level), 32'd3);
        idle(30);
        step(0, 0, 1);

        // restart, nine rises, then 10th rise when counter is about to wrap
        step(1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 0); step(0, 0, 0);
        end
        step(0, 1, 0);
        chk("lvlup_score", 32'(score), 32'd10);
        chk("lvlup_level", 32'(level), 32'd1);
        step(0, 0, 0);
        chk("lvlup_tick_next", 32'(move_tick), 32'd1);
        for (int i = 0; i < 17; i++) step(0, 0, 0);
        step(0, 0, 0);
        chk("lvlup_period18", 32'(move_tick), 32'd1);
        idle(20);
        step(0, 0, 1);

        // die priority and high score
        hard_reset();
        step(1, 0, 0);
        eats(4);
        step(0, 0, 1);
        step(1, 0, 0);
        eats(6);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 1, 1);
        chk("die_state", 32'(state), 32'd2);
        chk("die_score", 32'(score), 32'd7);
        chk("die_hs", 32'(high_score), HS_EN ? 32'd7 : 32'd0);
        chk("die_nr", 32'(new_record), HS_EN ? 32'd1 : 32'd0);
        step(0, 0, 0);
        step(1, 0, 0);
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_nr", 32'(new_record), 32'd0);
        chk("restart_hs", 32'(high_score), HS_EN ? 32'd7 : 32'd0);
        eats(7);
        step(0, 0, 1);
        chk("tie_nr", 32'(new_record), 32'd0);
        chk("tie_hs", 32'(high_score), HS_EN ? 32'd7 : 32'd0);

        // saturation with level checkpoints
        step(1, 0, 0);
        for (int i = 1; i <= 105; i++) begin
            step(0, 1, 0);
            step(0, 0, 0);
            if (i == 10) chk("sat_lvl_at10", 32'(level), 32'd1);
            if (i == 69) chk("sat_lvl_at69", 32'(level), 32'd6);
        end
        chk("sat_score", 32'(score), 32'd99);
        chk("sat_level", 32'(level), 32'd7);
        step(0, 0, 1);

        // randomized play
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 39) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
